// File: rtl/pong_pkg.sv
// pong_pkg: shared referee state, winner codes, widths and default timing for the pong slice
package pong_pkg;
  localparam int SPEED_W = 5;
  localparam int SCORE_W = 4;
  localparam int SERVE_TICKS_DEF = 2000;
  localparam int POINT_TICKS_DEF = 1000;
  localparam int RAMP_TICKS_DEF = 4000;
  localparam int SPEED_INIT_DEF = 4;
  localparam int SPEED_MAX_DEF = 15;
  localparam int WIN_SCORE_DEF = 9;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_LEFT = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAMEOVER} ref_state_e;
endpackage

// File: rtl/pong_referee_start_sync.sv
// start_sync: 2-flop synchroniser plus rising-edge pulse; in clk, reset, async d; out one-cycle rise
module start_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], d};
  always_ff @(posedge clk) s_q <= reset ? 3'b000 : s_d;
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/pong_referee.sv
// pong_referee: serve/rally/point/game-over sequencer; in start, out_left/out_right; out ball_reset, speed, scores, point pulses, winner, playing
module pong_referee
  import pong_pkg::*;
#(
  parameter int SERVE_TICKS = SERVE_TICKS_DEF,
  parameter int POINT_TICKS = POINT_TICKS_DEF,
  parameter int RAMP_TICKS = RAMP_TICKS_DEF,
  parameter int SPEED_INIT = SPEED_INIT_DEF,
  parameter int SPEED_MAX = SPEED_MAX_DEF,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic out_left,
  input  logic out_right,
  output logic ball_reset,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic point_l,
  output logic point_r,
  output logic [1:0] winner,
  output logic playing
);
  localparam logic signed [SPEED_W-1:0] S_INIT = SPEED_W'(SPEED_INIT);
  localparam logic signed [SPEED_W-1:0] S_MAX = SPEED_W'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  logic start_rise;
  ref_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic [1:0] winner_q, winner_d;
  logic ball_reset_q, ball_reset_d, playing_q, playing_d;
  logic point_l_q, point_l_d, point_r_q, point_r_d;
  start_sync u_start_sync (
    .clk(clk),
    .reset(reset),
    .d(start),
    .rise(start_rise)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 16'd1;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    speed_d = speed_q;
    winner_d = winner_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    case (state_q)
      IDLE, GAMEOVER: begin
        if (start_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d = WIN_NONE;
          state_d = SERVE;
        end
      end
      SERVE: if (timer_q == 16'(SERVE_TICKS - 1)) state_d = PLAY;
      PLAY: begin
        if (out_left && out_right) begin
          state_d = POINT;
        end else if (out_right) begin
          score_l_d = score_l_q + 1'b1;
          point_l_d = 1'b1;
          state_d = POINT;
        end else if (out_left) begin
          score_r_d = score_r_q + 1'b1;
          point_r_d = 1'b1;
          state_d = POINT;
        end else if (timer_q == 16'(RAMP_TICKS - 1)) begin
          timer_d = '0;
          speed_d = (speed_q < S_MAX) ? speed_q + 1'b1 : speed_q;
        end
      end
      POINT: begin
        if (timer_q == 16'(POINT_TICKS - 1)) begin
          winner_d = (score_l_q == WIN) ? WIN_LEFT : (score_r_q == WIN) ? WIN_RIGHT : WIN_NONE;
          state_d = (winner_d != WIN_NONE) ? GAMEOVER : SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    if (state_d == SERVE) speed_d = S_INIT;
    ball_reset_d = state_d != PLAY;
    playing_d = state_d == PLAY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      speed_q <= S_INIT;
      winner_q <= WIN_NONE;
      ball_reset_q <= 1'b1;
      playing_q <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      speed_q <= speed_d;
      winner_q <= winner_d;
      ball_reset_q <= ball_reset_d;
      playing_q <= playing_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
    end
  end
  assign ball_reset = ball_reset_q;
  assign speed = speed_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign winner = winner_q;
  assign playing = playing_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;
endmodule

// File: tb/tb_pong_referee.sv
// tb_pong_referee: randomized scenario bench for pong_referee against a rule-level game model
module tb_pong_referee;
  localparam int ST = 4, PT = 3, RT = 5, SI = 4, SM = 15, WS = 2;
  logic clk = 0, reset = 1, start = 0, out_left = 0, out_right = 0;
  logic ball_reset, point_l, point_r, playing;
  logic [4:0] speed;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  int sl = 0, sr = 0, k0 = 0;
  bit done;
  always #5 clk = ~clk;
  pong_referee #(
    .SERVE_TICKS(ST),
    .POINT_TICKS(PT),
    .RAMP_TICKS(RT),
    .SPEED_INIT(SI),
    .SPEED_MAX(SM),
    .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .out_left(out_left),
    .out_right(out_right),
    .ball_reset(ball_reset),
    .speed(speed),
    .score_l(score_l),
    .score_r(score_r),
    .point_l(point_l),
    .point_r(point_r),
    .winner(winner),
    .playing(playing)
  );
  task tick();
    @(posedge clk);
    #1;
  endtask
  function int exp_speed(int k);
    return (SI + k / RT > SM) ? SM : SI + k / RT;
  endfunction
  task test_reset();
    reset = 1;
    start = 0;
    out_left = 0;
    out_right = 0;
    tick();
    tick();
    reset = 0;
    sl = 0;
    sr = 0;
    checks++;
    if ({ball_reset, playing, point_l, point_r} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000", {ball_reset, playing, point_l, point_r});
    end
    checks++;
    if (speed !== 5'(SI) || score_l !== 0 || score_r !== 0 || winner !== 0) begin
      errors++;
      $display("FAIL reset_vals got speed=%0d sl=%0d sr=%0d w=%0d want 4 0 0 0", speed, score_l, score_r, winner);
    end
  endtask
  task test_start(input int hold, output int k);
    start = 1;
    for (int c = 1; c <= hold || c <= 3 + ST; c++) begin
      if (c > hold) start = 0;
      tick();
      checks++;
      if (c < 3 + ST) begin
        if (playing !== 0 || ball_reset !== 1) begin
          errors++;
          $display("FAIL serve_hold c=%0d got play=%b br=%b want 0 1", c, playing, ball_reset);
        end
      end else if (playing !== 1 || ball_reset !== 0 || speed !== 5'(exp_speed(c - 3 - ST))) begin
        errors++;
        $display("FAIL serve_play c=%0d got play=%b br=%b spd=%0d want 1 0 %0d", c, playing, ball_reset, speed, exp_speed(c - 3 - ST));
      end
      if (c < 3) begin
        checks++;
        if (score_l !== 4'(sl) || score_r !== 4'(sr)) begin
          errors++;
          $display("FAIL pre_start_hold got %0d:%0d want %0d:%0d", score_l, score_r, sl, sr);
        end
      end
      if (c == 3) begin
        sl = 0;
        sr = 0;
        checks++;
        if (score_l !== 0 || score_r !== 0 || winner !== 0 || speed !== 5'(SI)) begin
          errors++;
          $display("FAIL start_clear got %0d:%0d w=%0d spd=%0d want 0:0 w=0 spd=%0d", score_l, score_r, winner, speed, SI);
        end
      end
    end
    start = 0;
    k = (hold > 3 + ST) ? hold - 3 - ST : 0;
  endtask
  task test_rally(input int kb, input int len, input int ev, input bit stale, output bit over);
    over = 0;
    for (int k = kb; k < kb + len; k++) begin
      checks++;
      if (playing !== 1 || ball_reset !== 0 || speed !== 5'(exp_speed(k))) begin
        errors++;
        $display("FAIL rally k=%0d got play=%b br=%b spd=%0d want 1 0 %0d", k, playing, ball_reset, speed, exp_speed(k));
      end
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 0;
    if (ev == 0) return;
    out_right = (ev == 1 || ev == 3);
    out_left = (ev == 2 || ev == 3);
    tick();
    out_right = 0;
    out_left = 0;
    if (ev == 1) sl++;
    if (ev == 2) sr++;
    checks++;
    if (score_l !== 4'(sl) || score_r !== 4'(sr) || point_l !== (ev == 1) || point_r !== (ev == 2)) begin
      errors++;
      $display("FAIL point_ev ev=%0d got %0d:%0d pl=%b pr=%b want %0d:%0d pl=%b pr=%b", ev, score_l, score_r, point_l, point_r, sl, sr, ev == 1, ev == 2);
    end
    checks++;
    if (ball_reset !== 1 || playing !== 0 || speed !== 5'(exp_speed(kb + len))) begin
      errors++;
      $display("FAIL point_ctrl got br=%b play=%b spd=%0d want 1 0 %0d", ball_reset, playing, speed, exp_speed(kb + len));
    end
    for (int c = 1; c <= PT; c++) begin
      if (stale) begin
        out_left = 1'($urandom_range(0, 1));
        out_right = 1'($urandom_range(0, 1));
      end
      tick();
      checks++;
      if (point_l !== 0 || point_r !== 0 || score_l !== 4'(sl) || score_r !== 4'(sr) || ball_reset !== 1) begin
        errors++;
        $display("FAIL point_pause c=%0d got %0d:%0d pl=%b pr=%b br=%b want %0d:%0d 0 0 1", c, score_l, score_r, point_l, point_r, ball_reset, sl, sr);
      end
    end
    out_left = 0;
    out_right = 0;
    if (sl == WS || sr == WS) begin
      over = 1;
      for (int c = 0; c <= int'($urandom_range(0, 4)); c++) begin
        checks++;
        if (winner !== ((sl == WS) ? 2'b01 : 2'b10) || score_l !== 4'(sl) || score_r !== 4'(sr) || ball_reset !== 1 || playing !== 0) begin
          errors++;
          $display("FAIL gameover got w=%0d %0d:%0d br=%b want w=%0d %0d:%0d br=1", winner, score_l, score_r, ball_reset, (sl == WS) ? 1 : 2, sl, sr);
        end
        tick();
      end
      return;
    end
    checks++;
    if (speed !== 5'(SI) || winner !== 0) begin
      errors++;
      $display("FAIL reserve got spd=%0d w=%0d want %0d 0", speed, winner, SI);
    end
    for (int c = 1; c <= ST; c++) begin
      tick();
      checks++;
      if (playing !== (c == ST) || ball_reset !== (c != ST)) begin
        errors++;
        $display("FAIL reserve_wait c=%0d got play=%b br=%b want %b %b", c, playing, ball_reset, c == ST, c != ST);
      end
    end
  endtask
  task test_ramp_and_point();
    test_rally(k0, 60, 1, 0, done);
  endtask
  task test_both_with_stale();
    test_rally(0, $urandom_range(0, 12), 3, 1, done);
  endtask
  task test_left_wins();
    test_rally(0, $urandom_range(0, 12), 1, 0, done);
    checks++;
    if (done !== 1) begin
      errors++;
      $display("FAIL left_wins got over=%b want 1", done);
    end
    test_start(3 + ST, k0);
  endtask
  task test_reset_mid();
    test_rally(k0, 2, 2, 0, done);
    test_rally(0, 15, 0, 0, done);
    checks++;
    if (speed !== 5'd7 || score_r !== 4'd1 || playing !== 1) begin
      errors++;
      $display("FAIL pre_reset got spd=%0d sr=%0d play=%b want 7 1 1", speed, score_r, playing);
    end
    reset = 1;
    out_right = 1;
    tick();
    reset = 0;
    out_right = 0;
    sl = 0;
    sr = 0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (score_l !== 0 || score_r !== 0 || speed !== 5'(SI) || ball_reset !== 1 || playing !== 0 || point_l !== 0 || winner !== 0) begin
        errors++;
        $display("FAIL mid_reset c=%0d got %0d:%0d spd=%0d br=%b play=%b pl=%b w=%0d want idle", c, score_l, score_r, speed, ball_reset, playing, point_l, winner);
      end
      tick();
    end
  endtask
  task test_random_games();
    for (int g = 0; g < 6; g++) begin
      if (g == 3) test_reset();
      repeat (3) tick();
      test_start(3 + ST + $urandom_range(0, 4), k0);
      done = 0;
      for (int r = 0; r < 40 && !done; r++) begin
        test_rally(k0, $urandom_range(0, 30), $urandom_range(1, 3), 1'($urandom_range(0, 1)), done);
        k0 = 0;
      end
      checks++;
      if (done !== 1) begin
        errors++;
        $display("FAIL game_end g=%0d got over=%b want 1", g, done);
      end
    end
  endtask
  initial begin
    test_reset();
    test_start(10, k0);
    test_ramp_and_point();
    test_both_with_stale();
    test_left_wins();
    test_reset_mid();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
